// File: rtl/lp805x_sfrslave.sv
// lp805x_sfrslave: SFR slave with R0 data, R1 unlock key, R2 sticky flags, R3 key-protected; bit access under LP805X_SFRSLAVE_BIT_EN.
// Latency: registered read response, exactly 1 cycle; reads and writes accepted every cycle.
// Backpressure: none; a non-hit response is all-zero so several slaves can be OR-combined.
module lp805x_sfrslave #(
    parameter logic [7:0]  BASE_ADDR      = 8'hC0,
    parameter int unsigned UNLOCK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [28:0] sfr_bus,
    input  logic [7:0]  hw_flag_set,
    output logic [8:0]  sfr_rsp,
    output logic        rd_hit,
    output logic [7:0]  r0_q,
    output logic [7:0]  r3_q,
    output logic [7:0]  flags_q,
    output logic        unlocked
);

    typedef enum logic [1:0] {ST_LOCKED, ST_KEY1, ST_OPEN} state_t;

    localparam logic [7:0] TMO_LAST = 8'(UNLOCK_TIMEOUT - 1);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic [7:0] r_r0, r_r2, r_r3;
    logic [8:0] r_rsp;
    logic       r_rd_hit;

    logic [7:0] w_wr_addr, w_rd_addr, w_data_in;
    logic       w_wr, w_rd, w_bit_in, w_wr_bit, w_rd_bit;
    logic       w_wr_blk, w_rd_blk, w_wr_hit, w_rd_byte;
    logic       w_wr_r0, w_wr_r1, w_wr_r2, w_wr_r3;
    logic       w_bit_wr, w_bit_rd, w_timeout;
    logic [7:0] w_r2_keep, w_rd_data;

    assign {w_wr_addr, w_rd_addr, w_data_in, w_wr, w_rd, w_bit_in, w_wr_bit, w_rd_bit} = sfr_bus;

    // BASE_ADDR is 8-aligned: the byte registers occupy offsets 0..3 of the 8-address block
    assign w_wr_blk  = (w_wr_addr[7:3] == BASE_ADDR[7:3]);
    assign w_rd_blk  = (w_rd_addr[7:3] == BASE_ADDR[7:3]);
    assign w_wr_hit  = w_wr && w_wr_blk && !w_wr_addr[2];
    assign w_rd_byte = w_rd && w_rd_blk && !w_rd_addr[2];
    assign w_wr_r0   = w_wr_hit && (w_wr_addr[1:0] == 2'd0);
    assign w_wr_r1   = w_wr_hit && (w_wr_addr[1:0] == 2'd1);
    assign w_wr_r2   = w_wr_hit && (w_wr_addr[1:0] == 2'd2);
    assign w_wr_r3   = w_wr_hit && (w_wr_addr[1:0] == 2'd3);
    assign w_r2_keep = w_wr_r2 ? w_data_in : 8'hFF;

`ifdef LP805X_SFRSLAVE_BIT_EN
    assign w_bit_wr = w_wr_bit && !w_wr && w_wr_blk;
    assign w_bit_rd = w_rd_bit && w_rd_blk && !w_rd_byte;
`else
    logic w_unused_bit_ctl;
    assign w_unused_bit_ctl = w_wr_bit | w_rd_bit;
    assign w_bit_wr = 1'b0;
    assign w_bit_rd = 1'b0;
`endif

    always_comb begin
        w_rd_data = 8'h00;
        case (w_rd_addr[1:0])
            2'd0:    w_rd_data = r_r0;
            2'd2:    w_rd_data = r_r2;
            2'd3:    w_rd_data = r_r3;
            default: w_rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_r0     <= 8'h00;
            r_r2     <= 8'h00;
            r_r3     <= 8'h00;
            r_rsp    <= 9'h000;
            r_rd_hit <= 1'b0;
        end else begin
            if (w_wr_r0)
                r_r0 <= w_data_in;
            else if (w_bit_wr)
                r_r0[w_wr_addr[2:0]] <= w_bit_in;
            r_r2 <= (r_r2 & w_r2_keep) | hw_flag_set;
            if (w_wr_r3 && (r_state == ST_OPEN))
                r_r3 <= w_data_in;
            if (w_rd_byte)
                r_rsp <= {w_rd_data, 1'b0};
            else if (w_bit_rd)
                r_rsp <= {8'h00, r_r0[w_rd_addr[2:0]]};
            else
                r_rsp <= 9'h000;
            r_rd_hit <= w_rd_byte | w_bit_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOCKED;
            r_cnt   <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A key write always beats the timeout on the same cycle
    always_comb begin
        w_timeout   = (r_cnt == TMO_LAST);
        w_state_nxt = r_state;
        case (r_state)
            ST_LOCKED: if (w_wr_r1 && (w_data_in == 8'hAA)) w_state_nxt = ST_KEY1;
            ST_KEY1: begin
                if (w_wr_r1)        w_state_nxt = (w_data_in == 8'h55) ? ST_OPEN : ST_LOCKED;
                else if (w_timeout) w_state_nxt = ST_LOCKED;
            end
            ST_OPEN: begin
                if (w_wr_r1)                   w_state_nxt = (w_data_in == 8'hAA) ? ST_KEY1 : ST_LOCKED;
                else if (w_wr_r3 || w_timeout) w_state_nxt = ST_LOCKED;
            end
            default: w_state_nxt = ST_LOCKED;
        endcase
        // No transition leaves KEY1/OPEN in place, so any state change is an entry that reloads
        if ((w_state_nxt == ST_LOCKED) || (w_state_nxt != r_state))
            w_cnt_nxt = 8'h00;
        else
            w_cnt_nxt = r_cnt + 8'd1;
    end

    always_comb begin
        unlocked = (r_state == ST_OPEN);
    end

    assign sfr_rsp = r_rsp;
    assign rd_hit  = r_rd_hit;
    assign r0_q    = r_r0;
    assign r3_q    = r_r3;
    assign flags_q = r_r2;

endmodule

// File: tb/tb_lp805x_sfrslave.sv
// Bench for lp805x_sfrslave: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_lp805x_sfrslave;

    localparam int BASE   = 'hC0;
    localparam int T      = 16;
    localparam int LOCKED = 0;
    localparam int KEY1   = 1;
    localparam int OPEN   = 2;
`ifdef LP805X_SFRSLAVE_BIT_EN
    localparam bit BIT_EN = 1'b1;
`else
    localparam bit BIT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [28:0] sfr_bus;
    logic [7:0]  hw_flag_set;
    logic [8:0]  sfr_rsp;
    logic        rd_hit;
    logic [7:0]  r0_q, r3_q, flags_q;
    logic        unlocked;

    always #5 clk = ~clk;

    lp805x_sfrslave dut (
        .clk        (clk),
        .rst        (rst),
        .sfr_bus    (sfr_bus),
        .hw_flag_set(hw_flag_set),
        .sfr_rsp    (sfr_rsp),
        .rd_hit     (rd_hit),
        .r0_q       (r0_q),
        .r3_q       (r3_q),
        .flags_q    (flags_q),
        .unlocked   (unlocked)
    );

    int checks   = 0;
    int failures = 0;

    int m_r0, m_r2, m_r3, m_phase, m_age, m_rsp, m_hit;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [28:0] mk_bus(input logic [7:0] wa, input logic [7:0] ra, input logic [7:0] d,
                                          input logic wr, input logic rd, input logic bi,
                                          input logic wb, input logic rb);
        return {wa, ra, d, wr, rd, bi, wb, rb};
    endfunction

    // Reference: registers as integers, unlock progress as a phase plus cycles spent in it
    task automatic model_step(input logic r, input logic [28:0] b, input logic [7:0] hw);
        int  wa, ra, d, nr0, nr2, nr3;
        bit  wr, rd, bi, wb, rb, key, r3wr;
        wa = int'(b[28:21]); ra = int'(b[20:13]); d = int'(b[12:5]);
        wr = b[4]; rd = b[3]; bi = b[2]; wb = b[1]; rb = b[0];
        if (r) begin
            m_r0 = 0; m_r2 = 0; m_r3 = 0; m_phase = LOCKED; m_age = 0; m_rsp = 0; m_hit = 0;
        end else begin
            m_rsp = 0; m_hit = 0;
            if (rd && ra >= BASE && ra <= BASE + 3) begin
                m_hit = 1;
                case (ra - BASE)
                    0:       m_rsp = m_r0 * 2;
                    1:       m_rsp = 0;
                    2:       m_rsp = m_r2 * 2;
                    default: m_rsp = m_r3 * 2;
                endcase
            end else if (BIT_EN && rb && ra / 8 == BASE / 8) begin
                m_hit = 1;
                m_rsp = (m_r0 >> (ra % 8)) & 1;
            end
            nr0 = m_r0; nr2 = m_r2 | int'(hw); nr3 = m_r3; key = 0; r3wr = 0;
            if (wr && wa >= BASE && wa <= BASE + 3) begin
                case (wa - BASE)
                    0:       nr0 = d;
                    1:       key = 1;
                    2:       nr2 = (m_r2 & d) | int'(hw);
                    default: begin r3wr = 1; if (m_phase == OPEN) nr3 = d; end
                endcase
            end else if (BIT_EN && !wr && wb && wa / 8 == BASE / 8) begin
                if (bi) nr0 = m_r0 | (1 << (wa % 8));
                else    nr0 = m_r0 & (255 - (1 << (wa % 8)));
            end
            if (m_phase == LOCKED) begin
                if (key && d == 'hAA) begin m_phase = KEY1; m_age = 0; end
            end else if (key) begin
                if (m_phase == KEY1) m_phase = (d == 'h55) ? OPEN : LOCKED;
                else                 m_phase = (d == 'hAA) ? KEY1 : LOCKED;
                m_age = 0;
            end else if (m_phase == OPEN && r3wr) begin
                m_phase = LOCKED;
            end else begin
                m_age++;
                if (m_age >= T) begin m_phase = LOCKED; m_age = 0; end
            end
            m_r0 = nr0; m_r2 = nr2; m_r3 = nr3;
        end
    endtask

    task automatic step(input logic r, input logic [28:0] b, input logic [7:0] hw);
        rst = r; sfr_bus = b; hw_flag_set = hw;
        @(posedge clk);
        #1;
        model_step(r, b, hw);
        check_eq("r0_q",     32'(r0_q),     32'(m_r0));
        check_eq("flags_q",  32'(flags_q),  32'(m_r2));
        check_eq("r3_q",     32'(r3_q),     32'(m_r3));
        check_eq("sfr_rsp",  32'(sfr_rsp),  32'(m_rsp));
        check_eq("rd_hit",   32'(rd_hit),   32'(m_hit));
        check_eq("unlocked", 32'(unlocked), 32'(m_phase == OPEN));
    endtask

    task automatic idle();
        step(1'b0, 29'h0, 8'h00);
    endtask

    task automatic wr_byte(input logic [7:0] a, input logic [7:0] d);
        step(1'b0, mk_bus(a, 8'h00, d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 8'h00);
    endtask

    task automatic rd_byte(input logic [7:0] a);
        step(1'b0, mk_bus(8'h00, a, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 8'h00);
    endtask

    logic [7:0] wa, ra, d, hw;
    logic       wr, rd, bi, wb, rb, rr;

    initial begin
        rst = 1'b1; sfr_bus = 29'h0; hw_flag_set = 8'h00;
        step(1'b1, 29'h0, 8'hFF);
        step(1'b1, mk_bus(8'hC0, 8'hC0, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), 8'hFF);
        check_eq("rst_flags", 32'(flags_q), 32'h0);
        check_eq("rst_rsp", 32'(sfr_rsp), 32'h0);

        for (int i = 0; i < 4; i++) begin
            rd_byte(8'(BASE + i));
            check_eq("rd_after_rst_rsp", 32'(sfr_rsp), 32'h0);
            check_eq("rd_after_rst_hit", 32'(rd_hit), 32'h1);
        end

        wr_byte(8'hC1, 8'hAA);
        wr_byte(8'hC1, 8'h55);
        check_eq("unlock_open", 32'(unlocked), 32'h1);
        wr_byte(8'hC3, 8'h5A);
        check_eq("r3_written", 32'(r3_q), 32'h5A);
        check_eq("relock_after_r3", 32'(unlocked), 32'h0);
        wr_byte(8'hC3, 8'h11);
        check_eq("r3_second_dropped", 32'(r3_q), 32'h5A);

        wr_byte(8'hC1, 8'hAA);
        repeat (16) idle();
        wr_byte(8'hC1, 8'h55);
        check_eq("late_key_locked", 32'(unlocked), 32'h0);
        wr_byte(8'hC3, 8'h33);
        check_eq("late_key_r3", 32'(r3_q), 32'h5A);

        // Second key lands exactly on the timeout cycle and must still open
        wr_byte(8'hC1, 8'hAA);
        repeat (15) idle();
        wr_byte(8'hC1, 8'h55);
        check_eq("key_on_timeout", 32'(unlocked), 32'h1);
        repeat (15) idle();
        check_eq("open_before_tmo", 32'(unlocked), 32'h1);
        idle();
        check_eq("open_timeout", 32'(unlocked), 32'h0);

        // Data bit 0 is 1, so the hardware-set bit 0 survives; bit 7 is cleared and re-set together
        step(1'b0, 29'h0, 8'h81);
        step(1'b0, mk_bus(8'hC2, 8'h00, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 8'h80);
        check_eq("flag_set_wins", 32'(flags_q), 32'h81);
        wr_byte(8'hC2, 8'h00);
        check_eq("flag_clear", 32'(flags_q), 32'h00);

        step(1'b1, 29'h0, 8'h00);
        step(1'b0, mk_bus(8'hC5, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), 8'h00);
        check_eq("bit_wr_r0", 32'(r0_q), BIT_EN ? 32'h20 : 32'h00);
        step(1'b0, mk_bus(8'h00, 8'hC5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 8'h00);
        check_eq("bit_rd_rsp", 32'(sfr_rsp), BIT_EN ? 32'h001 : 32'h000);
        check_eq("bit_rd_hit", 32'(rd_hit), BIT_EN ? 32'h1 : 32'h0);
        step(1'b0, mk_bus(8'hC0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0), 8'h00);
        check_eq("byte_beats_bit", 32'(r0_q), 32'h00);

        wr_byte(8'hC0, 8'h12);
        step(1'b0, mk_bus(8'hC0, 8'hC0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), 8'h00);
        check_eq("rd_pre_write", 32'(sfr_rsp), 32'h024);
        check_eq("wr_applied", 32'(r0_q), 32'hFF);

        wr_byte(8'hC1, 8'hAA);
        wr_byte(8'hC1, 8'h55);
        step(1'b1, 29'h0, 8'h00);
        wr_byte(8'hC3, 8'h77);
        check_eq("r3_after_reset", 32'(r3_q), 32'h00);

        for (int n = 0; n < 3000; n++) begin
            wa = ($urandom_range(0, 9) < 8) ? 8'(BASE + $urandom_range(0, 7)) : 8'($urandom);
            ra = ($urandom_range(0, 9) < 8) ? 8'(BASE + $urandom_range(0, 7)) : 8'($urandom);
            case ($urandom_range(0, 3))
                0:       d = 8'hAA;
                1:       d = 8'h55;
                default: d = 8'($urandom);
            endcase
            wr = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            bi = 1'($urandom_range(0, 1));
            wb = ($urandom_range(0, 3) == 0);
            rb = ($urandom_range(0, 3) == 0);
            hw = 8'($urandom & $urandom & $urandom);
            rr = ($urandom_range(0, 199) == 0);
            step(rr, mk_bus(wa, ra, d, wr, rd, bi, wb, rb), hw);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
